// File: rtl/fpu_alu_exec_element.sv
// Single-precision FPU ALU element: each reset release runs one operation on fs/ft.
// Bit ops, ADD/SUB, MUL and conversions are combinational on latched operands; DIV/SQRT iterate.
module fpu_alu_exec_element (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  inst_num,
  input  logic [31:0] fs,
  input  logic [31:0] ft,
  output logic [31:0] out,
  output logic        completed
);
  // Handshake: reset high starts one operation; completed rises with out valid and holds until reset.
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [31:0] QNAN = 32'h7fffffff;

  state_t      state, state_nxt;
  logic [5:0]  op_q;
  logic [31:0] a_q, b_q, res_q, res_c;
  logic [4:0]  cnt_q, lat_m2;
  logic [24:0] div_r_q;
  logic [27:0] quo_q, root_q;
  logic [31:0] sq_rem_q, sq_t, sq_trial;
  logic [55:0] rad_q;
  logic [23:0] div_d;

  function automatic logic is_zero(input logic [31:0] v);
    return v[30:23] == 8'd0;
  endfunction
  function automatic logic is_inf(input logic [31:0] v);
    return v[30:23] == 8'hff && v[22:0] == 23'd0;
  endfunction
  function automatic logic is_nan(input logic [31:0] v);
    return v[30:23] == 8'hff && v[22:0] != 23'd0;
  endfunction

  function automatic logic [4:0] msb32(input logic [31:0] v);
    msb32 = '0;
    for (int i = 0; i < 32; i++) if (v[i]) msb32 = i[4:0];
  endfunction

  // Round-to-nearest-even on a normalised 24-bit mantissa, then overflow/underflow clamps.
  function automatic logic [31:0] pack(input logic s, input int e, input logic [23:0] m,
                                       input logic g, input logic st);
    logic [24:0] mr;
    int er;
    mr = {1'b0, m} + {24'd0, g & (st | m[0])};
    er = e;
    if (mr[24]) begin
      mr = mr >> 1;
      er = er + 1;
    end
    if (er >= 255) return {s, 8'hff, 23'd0};
    if (er <= 0) return {s, 31'd0};
    return {s, er[7:0], mr[22:0]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, tmp;
    logic [23:0] mx, my;
    logic [8:0]  d;
    logic [49:0] sh;
    logic [26:0] y27;
    logic [27:0] sum, nrm;
    logic [4:0]  p;
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && a[31] != b[31])) return QNAN;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    x = is_zero(a) ? {a[31], 31'd0} : a;
    y = is_zero(b) ? {b[31], 31'd0} : b;
    if (x[30:0] < y[30:0]) begin
      tmp = x; x = y; y = tmp;
    end
    mx  = {|x[30:23], x[22:0]};
    my  = {|y[30:23], y[22:0]};
    d   = {1'b0, x[30:23]} - {1'b0, y[30:23]};
    sh  = {my, 26'd0} >> d;
    y27 = sh[49:23] | {26'd0, (d >= 9'd27) ? |my : |sh[22:0]};
    if (x[31] == y[31]) sum = {1'b0, mx, 3'd0} + {1'b0, y27};
    else                sum = {1'b0, mx, 3'd0} - {1'b0, y27};
    if (sum == 28'd0) return 32'd0;
    p   = msb32({4'd0, sum});
    nrm = sum << (5'd27 - p);
    return pack(x[31], int'(x[30:23]) + int'(p) - 26, nrm[27:4], nrm[3], |nrm[2:0]);
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] pr;
    int          e;
    s = a[31] ^ b[31];
    if (is_nan(a) || is_nan(b)) return QNAN;
    if ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) return QNAN;
    if (is_inf(a) || is_inf(b)) return {s, 8'hff, 23'd0};
    if (is_zero(a) || is_zero(b)) return {s, 31'd0};
    pr = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (pr[47]) return pack(s, e + 1, pr[47:24], pr[23], |pr[22:0]);
    return pack(s, e, pr[46:23], pr[22], |pr[21:0]);
  endfunction

  function automatic logic [31:0] div_fin(input logic [31:0] a, input logic [31:0] b,
                                          input logic [27:0] q, input logic r_nz);
    logic s;
    int   e;
    s = a[31] ^ b[31];
    if (is_nan(a) || is_nan(b)) return QNAN;
    if ((is_zero(a) && is_zero(b)) || (is_inf(a) && is_inf(b))) return QNAN;
    if (is_inf(a) || is_zero(b)) return {s, 8'hff, 23'd0};
    if (is_zero(a) || is_inf(b)) return {s, 31'd0};
    e = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q[27]) return pack(s, e, q[27:4], q[3], |q[2:0] | r_nz);
    return pack(s, e - 1, q[26:3], q[2], |q[1:0] | r_nz);
  endfunction

  function automatic logic [31:0] sqrt_fin(input logic [31:0] a, input logic [27:0] root,
                                           input logic r_nz);
    if (is_nan(a)) return QNAN;
    if (is_zero(a)) return {a[31], 31'd0};
    if (a[31]) return QNAN;
    if (is_inf(a)) return a;
    return pack(1'b0, (int'(a[30:23]) + 126 + int'(a[23])) / 2, root[27:4], root[3],
                |root[2:0] | r_nz);
  endfunction

  function automatic logic [31:0] cvt_sw(input logic [31:0] a);
    logic [31:0] mag, n;
    logic [4:0]  p;
    if (a == 32'd0) return 32'd0;
    mag = a[31] ? -a : a;
    p   = msb32(mag);
    n   = mag << (5'd31 - p);
    return pack(a[31], 127 + int'(p), n[31:8], n[7], |n[6:0]);
  endfunction

  function automatic logic [31:0] cvt_ws(input logic [31:0] a);
    int          e;
    logic [63:0] t;
    logic [31:0] iv;
    if (is_nan(a)) return 32'h7fffffff;
    if (is_zero(a)) return 32'd0;
    e = int'(a[30:23]) - 127;
    if (e >= 31) return a[31] ? 32'h80000000 : 32'h7fffffff;
    if (e < -1) return 32'd0;
    t = {8'd0, 1'b1, a[22:0], 32'd0};
    if (e >= 23) t = t << (e - 23);
    else         t = t >> (23 - e);
    iv = t[63:32] + {31'd0, t[31] & ((|t[30:0]) | t[32])};
    return a[31] ? -iv : iv;
  endfunction

  assign div_d    = {|b_q[30:23], b_q[22:0]};
  assign sq_t     = {sq_rem_q[29:0], rad_q[55:54]};
  assign sq_trial = {2'b00, root_q, 2'b01};

  always_comb begin
    lat_m2 = 5'd0;
    case (op_q)
      6'd58:                      lat_m2 = 5'd1;
      6'd56, 6'd57, 6'd60, 6'd61: lat_m2 = 5'd2;
      6'd59, 6'd63:               lat_m2 = 5'd28;
      default:                    lat_m2 = 5'd0;
    endcase
  end

  always_comb begin
    res_c = 32'd0;
    case (op_q)
      6'd54:   res_c = {1'b0, a_q[30:0]};
      6'd55:   res_c = {~a_q[31], a_q[30:0]};
      6'd56:   res_c = fadd(a_q, b_q);
      6'd57:   res_c = fadd(a_q, {~b_q[31], b_q[30:0]});
      6'd58:   res_c = fmul(a_q, b_q);
      6'd59:   res_c = div_fin(a_q, b_q, quo_q, |div_r_q);
      6'd60:   res_c = cvt_sw(a_q);
      6'd61:   res_c = cvt_ws(a_q);
      6'd62:   res_c = a_q;
      6'd63:   res_c = sqrt_fin(a_q, root_q, |sq_rem_q);
      default: res_c = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = BUSY;
      BUSY:    if (cnt_q == lat_m2) state_nxt = DONE;
      default: state_nxt = DONE;
    endcase
  end

  always_comb begin
    completed = (state == DONE);
    out       = completed ? res_q : 32'd0;
  end

  // Divider and root both step every BUSY cycle; only the selected op's final value is used.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= '0; a_q <= '0; b_q <= '0; res_q <= '0; cnt_q <= '0;
      div_r_q <= '0; quo_q <= '0; root_q <= '0; sq_rem_q <= '0; rad_q <= '0;
    end else if (state == IDLE) begin
      op_q     <= inst_num;
      a_q      <= fs;
      b_q      <= ft;
      cnt_q    <= '0;
      div_r_q  <= {1'b0, |fs[30:23], fs[22:0]};
      quo_q    <= '0;
      root_q   <= '0;
      sq_rem_q <= '0;
      rad_q    <= fs[23] ? {1'b0, |fs[30:23], fs[22:0], 31'd0} : {|fs[30:23], fs[22:0], 32'd0};
    end else if (state == BUSY) begin
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == lat_m2) res_q <= res_c;
      if (div_r_q >= {1'b0, div_d}) begin
        quo_q   <= {quo_q[26:0], 1'b1};
        div_r_q <= (div_r_q - {1'b0, div_d}) << 1;
      end else begin
        quo_q   <= {quo_q[26:0], 1'b0};
        div_r_q <= div_r_q << 1;
      end
      if (sq_t >= sq_trial) begin
        sq_rem_q <= sq_t - sq_trial;
        root_q   <= {root_q[26:0], 1'b1};
      end else begin
        sq_rem_q <= sq_t;
        root_q   <= {root_q[26:0], 1'b0};
      end
      rad_q <= rad_q << 2;
    end
  end
endmodule

// File: tb/tb_fpu_alu_exec_element.sv
// Bench for fpu_alu_exec_element: directed vector table, reset/abort sequences and
// randomized operations checked against a real-arithmetic reference model.
module tb_fpu_alu_exec_element;
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  inst_num;
  logic [31:0] fs, ft, out;
  logic        completed;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] want;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  fpu_alu_exec_element dut (
    .clk(clk), .reset(reset), .inst_num(inst_num), .fs(fs), .ft(ft),
    .out(out), .completed(completed)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string what, input int idx, input logic [31:0] act,
                       input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s #%0d: got %08h, expected %08h", what, idx, act, want);
    end
  endtask

  function automatic int lat_of(input logic [5:0] op);
    case (op)
      6'd58:                      return 3;
      6'd56, 6'd57, 6'd60, 6'd61: return 4;
      6'd59, 6'd63:               return 30;
      default:                    return 2;
    endcase
  endfunction

  task automatic add_vec(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.want = want; v.lat = lat_of(op);
    vecs.push_back(v);
  endtask

  // Reference model: single <-> real, IEEE ops in double, then round to single.
  function automatic real s2r(input logic [31:0] v);
    if (v[30:23] == 8'd0) return 0.0;
    return $bitstoreal({v[31], 11'(int'(v[30:23]) - 127 + 1023), v[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [52:0] m;
    logic [24:0] kr;
    int          e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e  = int'(d[62:52]) - 1023;
    m  = {1'b1, d[51:0]};
    kr = {1'b0, m[52:29]};
    if (m[28:0] > 29'h10000000 || (m[28:0] == 29'h10000000 && kr[0])) kr = kr + 25'd1;
    if (kr[24]) begin
      kr = kr >> 1;
      e  = e + 1;
    end
    if (e > 127) return {d[63], 8'hff, 23'd0};
    if (e < -126) return {d[63], 31'd0};
    return {d[63], 8'(e + 127), kr[22:0]};
  endfunction

  function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    real    r, fr;
    longint n;
    int     iv;
    case (op)
      6'd54: return {1'b0, a[30:0]};
      6'd55: return {~a[31], a[30:0]};
      6'd62: return a;
      6'd56, 6'd57: begin
        r = (op == 6'd56) ? s2r(a) + s2r(b) : s2r(a) - s2r(b);
        return (r == 0.0) ? 32'd0 : r2s(r);
      end
      6'd58: return r2s(s2r(a) * s2r(b));
      6'd59: return r2s(s2r(a) / s2r(b));
      6'd60: begin
        iv = a;
        return (iv == 0) ? 32'd0 : r2s(real'(iv));
      end
      6'd61: begin
        r  = s2r(a);
        n  = $rtoi(r);
        fr = r - real'(n);
        if (fr > 0.5 || (fr == 0.5 && n[0])) n = n + 1;
        if (fr < -0.5 || (fr == -0.5 && n[0])) n = n - 1;
        if (n > 64'sd2147483647) return 32'h7fffffff;
        if (n < -64'sd2147483648) return 32'h80000000;
        return n[31:0];
      end
      6'd63: return r2s($sqrt(s2r(a)));
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_f(input int lo, input int hi, input bit pos);
    logic s;
    s = pos ? 1'b0 : 1'($urandom_range(0, 1));
    return {s, 8'($urandom_range(lo, hi)), 23'($urandom)};
  endfunction

  // Reset pulse, apply operands, release away from the clock edge, count edges to completion.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    reset = 1'b0;
    @(negedge clk);
    inst_num = op; fs = a; ft = b;
    @(negedge clk);
    reset = 1'b1;
    lat = 0;
    res = 32'd0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (completed) begin
        lat = i;
        res = out;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] res, a, b, held;
    logic [5:0]  op;
    int          lat, r;

    reset = 1'b0; inst_num = '0; fs = '0; ft = '0;
    #3;
    check("reset_completed", 0, {31'd0, completed}, 32'd0);
    check("reset_out", 0, out, 32'd0);

    add_vec(6'd54, 32'hffffffff, 32'h0,        32'h7fffffff);
    add_vec(6'd55, 32'h7fffffff, 32'h0,        32'hffffffff);
    add_vec(6'd55, 32'hffffffff, 32'h0,        32'h7fffffff);
    add_vec(6'd62, 32'hf468fa99, 32'h1,        32'hf468fa99);
    add_vec(6'd56, 32'h4048f5c3, 32'h411ffbe7, 32'h41523958);
    add_vec(6'd56, 32'h4048f5c3, 32'hc11ffbe7, 32'hc0db7cec);
    add_vec(6'd57, 32'hc048f5c3, 32'h411ffbe7, 32'hc1523958);
    add_vec(6'd57, 32'hc048f5c3, 32'hc11ffbe7, 32'h40db7cec);
    add_vec(6'd58, 32'h4048f5c3, 32'h411ffbe7, 32'h41fb2cc5);
    add_vec(6'd58, 32'h4048f5c3, 32'hc11ffbe7, 32'hc1fb2cc5);
    add_vec(6'd58, 32'hc048f5c3, 32'h411ffbe7, 32'hc1fb2cc5);
    add_vec(6'd58, 32'hc048f5c3, 32'hc11ffbe7, 32'h41fb2cc5);
    add_vec(6'd59, 32'h4048f5c3, 32'h411ffbe7, 32'h3ea0c8ba);
    add_vec(6'd59, 32'h4048f5c3, 32'hc11ffbe7, 32'hbea0c8ba);
    add_vec(6'd59, 32'hc048f5c3, 32'h411ffbe7, 32'hbea0c8ba);
    add_vec(6'd59, 32'hc048f5c3, 32'hc11ffbe7, 32'h3ea0c8ba);
    add_vec(6'd60, 32'd1234567,  32'h0,        32'h4996b438);
    add_vec(6'd60, -32'sd98765432, 32'h0,      32'hccbc614f);
    add_vec(6'd63, 32'h4b3c614e, 32'h0,        32'h455b9a44);
    add_vec(6'd61, 32'h4996b438, 32'h0,        32'd1234567);
    add_vec(6'd59, 32'h3f800000, 32'h00000000, 32'h7f800000);
    add_vec(6'd63, 32'hbf800000, 32'h0,        32'h7fffffff);
    add_vec(6'd0,  32'h12345678, 32'h9abcdef0, 32'h00000000);
    add_vec(6'd60, 32'h80000000, 32'h0,        32'hcf000000);
    add_vec(6'd60, 32'h00000000, 32'h0,        32'h00000000);
    add_vec(6'd61, 32'h7fc00000, 32'h0,        32'h7fffffff);
    add_vec(6'd61, 32'hcf800000, 32'h0,        32'h80000000);
    add_vec(6'd61, 32'h4f800000, 32'h0,        32'h7fffffff);
    add_vec(6'd61, 32'h3f000000, 32'h0,        32'h00000000);
    add_vec(6'd61, 32'h3fc00000, 32'h0,        32'h00000002);
    add_vec(6'd56, 32'h4048f5c3, 32'hc048f5c3, 32'h00000000);
    add_vec(6'd58, 32'h7f800000, 32'h00000000, 32'h7fffffff);
    add_vec(6'd59, 32'h00000000, 32'h80000000, 32'h7fffffff);
    add_vec(6'd59, 32'hbf800000, 32'h00000000, 32'hff800000);
    add_vec(6'd63, 32'h80000000, 32'h0,        32'h80000000);
    add_vec(6'd63, 32'h40000000, 32'h0,        32'h3fb504f3);
    add_vec(6'd63, 32'h40800000, 32'h0,        32'h40000000);
    add_vec(6'd58, 32'h7f000000, 32'h40000000, 32'h7f800000);
    add_vec(6'd58, 32'h00800000, 32'h3f000000, 32'h00000000);
    add_vec(6'd56, 32'h7fc00000, 32'h3f800000, 32'h7fffffff);
    add_vec(6'd57, 32'h7f800000, 32'h7f800000, 32'h7fffffff);
    add_vec(6'd54, 32'h7fc00001, 32'h0,        32'h7fc00001);

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check("vec_out", i, res, vecs[i].want);
      check("vec_lat", i, lat, vecs[i].lat);
    end

    // Abort a DIV at cycle 10, then run a fresh DIV while the inputs wander after latching.
    reset = 1'b0;
    @(negedge clk);
    inst_num = 6'd59; fs = 32'h4048f5c3; ft = 32'h411ffbe7;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_completed", 0, {31'd0, completed}, 32'd0);
    check("abort_out", 0, out, 32'd0);
    @(negedge clk);
    inst_num = 6'd59; fs = 32'h3f800000; ft = 32'h40000000;
    @(negedge clk);
    reset = 1'b1;
    lat = 0;
    res = 32'd0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) begin
        inst_num = 6'd0; fs = 32'hdeadbeef; ft = 32'h0;
      end
      if (completed) begin
        lat = i;
        res = out;
        break;
      end
    end
    check("restart_out", 0, res, 32'h3f000000);
    check("restart_lat", 0, lat, 32'd30);
    held = res;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("hold_out", i, out, held);
      check("hold_completed", i, {31'd0, completed}, 32'd1);
    end
    #2 reset = 1'b0;
    #1;
    check("done_reset_completed", 0, {31'd0, completed}, 32'd0);
    check("done_reset_out", 0, out, 32'd0);

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 10);
      op = (r == 10) ? 6'($urandom_range(0, 53)) : 6'(54 + r);
      a = $urandom;
      b = $urandom;
      case (op)
        6'd56, 6'd57, 6'd58, 6'd59: begin
          a = rand_f(100, 154, 1'b0);
          b = rand_f(100, 154, 1'b0);
        end
        6'd61:   a = rand_f(100, 157, 1'b0);
        6'd63:   a = rand_f(60, 200, 1'b1);
        default: ;
      endcase
      exp_q.push_back(model(op, a, b));
      run_op(op, a, b, res, lat);
      check("rand_out", k, res, exp_q.pop_front());
      check("rand_lat", k, lat, lat_of(op));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
